// File: rtl/lcd_pkg.sv
// Shared types and field positions for the character-LCD output engine.
package lcd_pkg;

   typedef enum logic [2:0] {INIT, IDLE, SETUP, EN_HI, HOLD, WAIT} lcd_state_e;

   localparam int unsigned DATA_LSB = 0;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned RS_BIT   = 8;
   localparam int unsigned REQ_BIT  = 30;
   localparam int unsigned ON_BIT   = 31;

   localparam int unsigned BUSY_BIT = 0;
   localparam int unsigned ACK_BIT  = 1;
   localparam int unsigned INIT_BIT = 2;

   // A zero-length phase still occupies one cycle.
   function automatic int unsigned eff_len(int unsigned cyc);
      return (cyc == 0) ? 1 : cyc;
   endfunction

   // Clear display / return home need the long execution wait.
   function automatic logic is_long_cmd(logic rs, logic [DATA_W-1:0] data);
      return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
   endfunction

   function automatic int unsigned max2(int unsigned a, int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// Register-side link between the load/store unit and the LCD engine.
interface lcd_driver_if;
   logic [31:0] lcd_word;
   logic [31:0] lcd_status;

   modport master (output lcd_word, input lcd_status);
   modport slave  (input lcd_word, output lcd_status);
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every phase of the LCD bus cycle.
module lcd_timer #(
   parameter int unsigned           WIDTH     = 17,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_done
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= RESET_VAL;
      end else if (i_load) begin
         cnt_q <= i_value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_driver.sv
// HD44780-style write engine driven by the memory-mapped LCD command word.
// Define LCD_LONG_WAIT_EN to give clear/home commands the long execution wait.
module lcd_driver
   import lcd_pkg::*;
#(
   parameter int unsigned P_POWERUP_CYC   = 750000,
   parameter int unsigned P_SETUP_CYC     = 3,
   parameter int unsigned P_PULSE_CYC     = 12,
   parameter int unsigned P_HOLD_CYC      = 3,
   parameter int unsigned P_EXEC_CYC      = 2500,
   parameter int unsigned P_LONG_EXEC_CYC = 82000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   lcd_driver_if.slave       bus,
   output logic [DATA_W-1:0] o_lcd_data,
   output logic              o_lcd_rs,
   output logic              o_lcd_rw,
   output logic              o_lcd_en,
   output logic              o_lcd_on
);

   localparam int unsigned MAX_CYC = max2(max2(max2(eff_len(P_POWERUP_CYC),
      eff_len(P_SETUP_CYC)), max2(eff_len(P_PULSE_CYC), eff_len(P_HOLD_CYC))),
      max2(eff_len(P_EXEC_CYC), eff_len(P_LONG_EXEC_CYC)));
   localparam int unsigned TW = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

   localparam logic [TW-1:0] POWERUP_LD = TW'(eff_len(P_POWERUP_CYC) - 1);
   localparam logic [TW-1:0] SETUP_LD   = TW'(eff_len(P_SETUP_CYC) - 1);
   localparam logic [TW-1:0] PULSE_LD   = TW'(eff_len(P_PULSE_CYC) - 1);
   localparam logic [TW-1:0] HOLD_LD    = TW'(eff_len(P_HOLD_CYC) - 1);
   localparam logic [TW-1:0] EXEC_LD    = TW'(eff_len(P_EXEC_CYC) - 1);
   localparam logic [TW-1:0] LONG_LD    = TW'(eff_len(P_LONG_EXEC_CYC) - 1);

   lcd_state_e        state_q, state_d;
   logic              ack_q, ack_d;
   logic              req_q, req_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rs_q, rs_d;
   logic              en_q;
   logic              on_q;
   logic [2:0]        status_q;
   logic              tmr_load;
   logic [TW-1:0]     tmr_value;
   logic [TW-1:0]     exec_ld;
   logic              tmr_done;
   logic              unused_word_bits;

   assign unused_word_bits = ^bus.lcd_word[REQ_BIT-1:RS_BIT+1];

   // The INIT phase is timed from the counter's reset value.
   lcd_timer #(
      .WIDTH     (TW),
      .RESET_VAL (POWERUP_LD)
   ) u_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (tmr_load),
      .i_value (tmr_value),
      .o_done  (tmr_done)
   );

`ifdef LCD_LONG_WAIT_EN
   assign exec_ld = is_long_cmd(rs_q, data_q) ? LONG_LD : EXEC_LD;
`else
   assign exec_ld = EXEC_LD;
`endif

   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      req_d     = req_q;
      data_d    = data_q;
      rs_d      = rs_q;
      tmr_load  = 1'b0;
      tmr_value = '0;
      unique case (state_q)
         INIT: begin
            if (tmr_done) state_d = IDLE;
         end
         IDLE: begin
            if (bus.lcd_word[REQ_BIT] != ack_q) begin
               state_d   = SETUP;
               data_d    = bus.lcd_word[DATA_LSB +: DATA_W];
               rs_d      = bus.lcd_word[RS_BIT];
               req_d     = bus.lcd_word[REQ_BIT];
               tmr_load  = 1'b1;
               tmr_value = SETUP_LD;
            end
         end
         SETUP: begin
            if (tmr_done) begin
               state_d   = EN_HI;
               tmr_load  = 1'b1;
               tmr_value = PULSE_LD;
            end
         end
         EN_HI: begin
            if (tmr_done) begin
               state_d   = HOLD;
               tmr_load  = 1'b1;
               tmr_value = HOLD_LD;
            end
         end
         HOLD: begin
            if (tmr_done) begin
               state_d   = WAIT;
               tmr_load  = 1'b1;
               tmr_value = exec_ld;
            end
         end
         WAIT: begin
            if (tmr_done) begin
               state_d = IDLE;
               ack_d   = req_q;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= INIT;
         ack_q    <= 1'b0;
         req_q    <= 1'b0;
         data_q   <= '0;
         rs_q     <= 1'b0;
         en_q     <= 1'b0;
         on_q     <= 1'b0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         req_q    <= req_d;
         data_q   <= data_d;
         rs_q     <= rs_d;
         en_q     <= (state_d == EN_HI);
         on_q     <= bus.lcd_word[ON_BIT];
         status_q[BUSY_BIT] <= (state_d != IDLE);
         status_q[ACK_BIT]  <= ack_d;
         status_q[INIT_BIT] <= (state_d != INIT);
      end
   end

   assign bus.lcd_status = {29'b0, status_q};
   assign o_lcd_data     = data_q;
   assign o_lcd_rs       = rs_q;
   assign o_lcd_rw       = 1'b0;
   assign o_lcd_en       = en_q;
   assign o_lcd_on       = on_q;

endmodule
